// File: rtl/cooper_exec_pkg.sv
// CooperCPU execute-stage shared types.
// Operation codes, execute FSM states and the default datapath width.
package cooper_exec_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_ADDU,
        OP_SUB,
        OP_SUBU,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_NOR,
        OP_SLT,
        OP_SLTU,
        OP_SLL,
        OP_SRL,
        OP_SRA,
        OP_SLLV,
        OP_SRLV,
        OP_SRAV,
        OP_LUI,
        OP_MFHI,
        OP_MFLO,
        OP_MTHI,
        OP_MTLO,
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } alu_fsm_t;

    function automatic logic is_muldiv(alu_op_t op);
        return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/exec_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Signed operands run as magnitudes; the sign is restored on the final step.
module exec_muldiv_iter
    import cooper_exec_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            start,
    input  logic            is_div,
    input  logic            is_signed,
    input  logic            active,
    input  logic            kill,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic [XLEN-1:0]   acc_q;
    logic [XLEN-1:0]   lsw_q;
    logic [XLEN-1:0]   m_q;
    logic [SHW-1:0]    cnt_q;
    logic              div_q;
    logic              neg_lo_q;
    logic              neg_hi_q;

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     shl;
    logic [XLEN:0]     diff;
    logic              ge;
    logic [XLEN-1:0]   acc_d;
    logic [XLEN-1:0]   lsw_d;
    logic [2*XLEN-1:0] prod;

    assign a_neg = is_signed & op_a[XLEN-1];
    assign b_neg = is_signed & op_b[XLEN-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    always_comb begin
        sum  = {1'b0, acc_q} + (lsw_q[0] ? {1'b0, m_q} : '0);
        shl  = {acc_q, lsw_q[XLEN-1]};
        diff = shl - {1'b0, m_q};
        ge   = shl >= {1'b0, m_q};
        if (div_q) begin
            acc_d = ge ? diff[XLEN-1:0] : shl[XLEN-1:0];
            lsw_d = {lsw_q[XLEN-2:0], ge};
        end else begin
            acc_d = sum[XLEN:1];
            lsw_d = {sum[0], lsw_q[XLEN-1:1]};
        end
    end

    assign done = active & ~kill & (cnt_q == SHW'(XLEN - 1));
    assign prod = neg_lo_q ? -{acc_d, lsw_d} : {acc_d, lsw_d};

    always_comb begin
        if (div_q) begin
            hi = neg_hi_q ? -acc_d : acc_d;
            lo = neg_lo_q ? -lsw_d : lsw_d;
        end else begin
            hi = prod[2*XLEN-1:XLEN];
            lo = prod[XLEN-1:0];
        end
    end

    // Zero divisor keeps an all-ones quotient and the dividend as remainder.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc_q    <= '0;
            lsw_q    <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else if (start) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            div_q    <= is_div;
            lsw_q    <= is_div ? a_mag : b_mag;
            m_q      <= is_div ? b_mag : a_mag;
            neg_lo_q <= (a_neg ^ b_neg) & ~(is_div & ~|op_b);
            neg_hi_q <= a_neg;
        end else if (active) begin
            if (kill) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + SHW'(1);
                acc_q <= acc_d;
                lsw_q <= lsw_d;
            end
        end
    end

endmodule

// File: rtl/exec_unit_md.sv
// CooperCPU multi-cycle execute stage: ALU, branch target, HI/LO, mul/div.
// Stalls upstream via in_ready while the iterative unit is busy.
module exec_unit_md
    import cooper_exec_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            kill,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [SHW-1:0]  shamt,
    input  logic [XLEN-1:0] pc_plus_4,
    input  logic [XLEN-1:0] imme,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            overflow,
    output logic [XLEN-1:0] addr_result,
    output logic            busy
);

    alu_op_t         op;
    alu_fsm_t        state_q;
    alu_fsm_t        state_d;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic            accept;
    logic            md_op;
    logic            md_start;
    logic            md_div;
    logic            md_signed;
    logic            md_done;
    logic [XLEN-1:0] md_hi;
    logic [XLEN-1:0] md_lo;
    logic [XLEN-1:0] add_r;
    logic [XLEN-1:0] sub_r;
    logic [XLEN-1:0] alu_res;
    logic            alu_ovf;
    logic [SHW-1:0]  vsh;

    assign op        = alu_op_t'(alu_op);
    assign busy      = (state_q != IDLE);
    assign in_ready  = ~busy;
    assign accept    = in_valid & in_ready;
    assign md_op     = is_muldiv(op);
    assign md_start  = accept & md_op;
    assign md_div    = op inside {OP_DIV, OP_DIVU};
    assign md_signed = op inside {OP_MULT, OP_DIV};
    assign add_r     = src_a + src_b;
    assign sub_r     = src_a - src_b;
    assign vsh       = src_a[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = add_r;
                alu_ovf = (src_a[XLEN-1] == src_b[XLEN-1]) &&
                          (add_r[XLEN-1] != src_a[XLEN-1]);
            end
            OP_SUB: begin
                alu_res = sub_r;
                alu_ovf = (src_a[XLEN-1] != src_b[XLEN-1]) &&
                          (sub_r[XLEN-1] != src_a[XLEN-1]);
            end
            OP_ADDU: alu_res = add_r;
            OP_SUBU: alu_res = sub_r;
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_NOR:  alu_res = ~(src_a | src_b);
            OP_SLT:  alu_res = XLEN'($signed(src_a) < $signed(src_b));
            OP_SLTU: alu_res = XLEN'(src_a < src_b);
            OP_SLL:  alu_res = src_b << shamt;
            OP_SRL:  alu_res = src_b >> shamt;
            OP_SRA:  alu_res = $signed(src_b) >>> shamt;
            OP_SLLV: alu_res = src_b << vsh;
            OP_SRLV: alu_res = src_b >> vsh;
            OP_SRAV: alu_res = $signed(src_b) >>> vsh;
            OP_LUI:  alu_res = src_b << (XLEN / 2);
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_MTHI: alu_res = src_a;
            OP_MTLO: alu_res = src_a;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (md_start)
                    state_d = md_div ? DIV : MUL;
            end
            MUL, DIV: begin
                if (kill || md_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    exec_muldiv_iter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_iter (
        .clock     (clock),
        .resetn    (resetn),
        .start     (md_start),
        .is_div    (md_div),
        .is_signed (md_signed),
        .active    (busy),
        .kill      (kill),
        .op_a      (src_a),
        .op_b      (src_b),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    // Completion and accept never coincide: accept needs the unit idle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            result      <= '0;
            zero        <= 1'b1;
            overflow    <= 1'b0;
            addr_result <= '0;
            out_valid   <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= 1'b0;
            if (md_done) begin
                hi_q      <= md_hi;
                lo_q      <= md_lo;
                result    <= md_lo;
                zero      <= (md_lo == '0);
                overflow  <= 1'b0;
                out_valid <= 1'b1;
            end else if (accept) begin
                addr_result <= pc_plus_4 + (imme << 2);
                if (!md_op) begin
                    result    <= alu_res;
                    zero      <= (alu_res == '0);
                    overflow  <= alu_ovf;
                    out_valid <= 1'b1;
                end
                if (op == OP_MTHI)
                    hi_q <= src_a;
                if (op == OP_MTLO)
                    lo_q <= src_a;
            end
        end
    end

endmodule

// File: doc/exec_unit_md.md
# exec_unit_md

Parametrised, multi-cycle execute stage for CooperCPU. It is the successor to the single-cycle combinational ALU. It keeps the full integer ALU and the branch-target adder, and adds iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers, MFHI/MFLO/MTHI/MTLO, and signed-overflow detection. It sits between the decoder/controller and memory/writeback, with a valid/ready handshake that stalls the pipeline while a multiply or divide iterates.

## Interface
Parameters:
- XLEN, 32, datapath width (power of two, ≥8)
- SHW, $clog2(XLEN), shift-amount width

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- in_valid  in  1  decoded operation present
- in_ready  out  1  unit can accept an operation this cycle
- kill  in  1  synchronous abort of in-flight mul/div
- alu_op  in  5  operation code (alu_op_t)
- src_a  in  XLEN  operand A (rs)
- src_b  in  XLEN  operand B (rt or extended immediate, already muxed)
- shamt  in  SHW  immediate shift amount
- pc_plus_4  in  XLEN  PC+4 of this instruction
- imme  in  XLEN  sign-extended immediate for branch target
- out_valid  out  1  one-cycle pulse: result/flags valid
- result  out  XLEN  registered result
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB only)
- addr_result  out  XLEN  pc_plus_4 + (imme << 2), registered
- busy  out  1  mul/div iterating

## Operation
- Accept occurs when in_valid && in_ready. in_ready = !busy.
- Single-cycle ops: ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, LUI, MFHI, MFLO, MTHI, MTLO.
- Variable shifts use src_a[SHW-1:0]. LUI gives src_b << (XLEN/2).
- overflow is set only for ADD/SUB on signed overflow. result is still the wrapped value, and the writeback suppression decision lies outside this unit.
- MTHI/MTLO write src_a to HI/LO; result = src_a.
- MULT/MULTU: shift-add, one bit per cycle, XLEN iterations. {HI,LO} = full 2·XLEN product. Signed is handled by magnitude then negate.
- DIV/DIVU: restoring, one bit per cycle, XLEN iterations. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Divide by zero: LO = all ones, HI = src_a. Signed min ÷ −1: LO = min, HI = 0.
- Mul/div completion: result = LO, zero = (LO==0), overflow = 0.
- FSM alu_fsm_t:
  - IDLE → MUL on accepted MULT/MULTU.
  - IDLE → DIV on accepted DIV/DIVU.
  - MUL/DIV → IDLE when the iteration counter reaches XLEN−1, or on kill.
- kill in IDLE has no effect. kill in MUL/DIV returns to IDLE next edge, leaves HI/LO unchanged, and produces no out_valid.
- Unknown alu_op: result = 0, out_valid still pulses.

## Timing
- Reset values: state IDLE, HI = LO = 0, result = 0, addr_result = 0, out_valid = 0, zero = 1, overflow = 0, busy = 0, counter = 0.
- Single-cycle op accepted at edge N: outputs valid and out_valid = 1 after edge N+1, for exactly one cycle. MFHI right after MTHI sees the new value (back-to-back accept allowed).
- Mul/div accepted at edge N: busy = 1 and in_ready = 0 from N+1 through N+XLEN. HI/LO and result are updated and out_valid pulses after edge N+XLEN+1. in_ready is 1 again in that cycle.
- in_valid while busy is ignored. The upstream holds the instruction.
- kill and final iteration on the same edge: kill wins.
- Reset mid-iteration: all state is reset immediately (async).
- addr_result and zero/overflow are registered alongside result and share its out_valid.

## Structure
- Package cooper_exec_pkg holds alu_op_t (5-bit enum, all codes above), alu_fsm_t {IDLE, MUL, DIV}, and XLEN_DEFAULT.
- One sub-module, exec_muldiv_iter, owns the iteration registers, the counter, signed fixup, and the divide-by-zero and overflow cases. It exposes start/kill/done/hi/lo.
- Top level holds the ALU datapath, HI/LO, the output registers, and the handshake.

## Test plan
- Reset with resetn=0 mid-DIV → all outputs at reset values; HI=LO=0; in_ready=1 after release.
- ADD 0x7FFFFFFF+1 → result 0x80000000, overflow=1, out_valid one cycle after accept. ADDU of the same operands → overflow=0.
- MULT −3 × 7 → after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB; in_ready=0 for exactly 32 cycles. MFHI next → 0xFFFFFFFF.
- DIV −7 ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 5 ÷ 0 → LO=0xFFFFFFFF, HI=5.
- kill asserted at iteration 10 of MULTU → no out_valid, HI/LO retain their prior values, next ADD accepted the following cycle.
- SUB equal operands with pc_plus_4=0x100, imme=0xFFFFFFFF → zero=1, addr_result=0xFC. Repeat at XLEN=16 for SRA 0x8000 by 15 → 0xFFFF.
